// File: rtl/n64_joybus_pkg.sv
// ============================================================================
// Module      : n64_joybus_pkg
// Description : Shared command codes, reply constants and FSM states for the
//               device-side joybus responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package n64_joybus_pkg;

  localparam logic [7:0] CMD_INFO  = 8'h00;
  localparam logic [7:0] CMD_POLL  = 8'h01;
  localparam logic [7:0] CMD_RESET = 8'hFF;

  localparam logic [7:0] INFO_HDR0 = 8'h05;
  localparam logic [7:0] INFO_HDR1 = 8'h00;

  localparam int BIT1_LOW_US = 1;
  localparam int BIT0_LOW_US = 3;
  localparam int CELL_US     = 4;
  localparam int STOP_LOW_US = 2;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_RX_LOW     = 4'd1,
    S_RX_HIGH    = 4'd2,
    S_RX_STOP    = 4'd3,
    S_TURNAROUND = 4'd4,
    S_TX_LOW     = 4'd5,
    S_TX_HIGH    = 4'd6,
    S_TX_STOP    = 4'd7,
    S_WAIT_IDLE  = 4'd8
  } jb_state_e;

  function automatic logic is_supported(input logic [7:0] cmd);
    return (cmd == CMD_INFO) || (cmd == CMD_POLL) || (cmd == CMD_RESET);
  endfunction

endpackage

`default_nettype wire

// File: rtl/joybus_bit_encoder.sv
// ============================================================================
// Module      : joybus_bit_encoder
// Description : Drives one reply byte as joybus cells (MSB first) and, for
//               the last byte, the trailing 2 us stop low.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module joybus_bit_encoder
  import n64_joybus_pkg::*;
#(
  parameter int CLK_PER_US = 48
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  input  logic       i_last,
  output logic       o_oe,
  output logic       o_stop,
  output logic       o_byte_done
);

  localparam int c_cell_cyc = CELL_US * CLK_PER_US;
  localparam int c_cw       = $clog2(c_cell_cyc);
  localparam logic [c_cw-1:0] c_cell_end = c_cw'(c_cell_cyc - 1);
  localparam logic [c_cw-1:0] c_stop_end = c_cw'(STOP_LOW_US * CLK_PER_US - 1);
  localparam logic [c_cw-1:0] c_low1     = c_cw'(BIT1_LOW_US * CLK_PER_US);
  localparam logic [c_cw-1:0] c_low0     = c_cw'(BIT0_LOW_US * CLK_PER_US);

  logic            r_active;
  logic            r_stop;
  logic            r_last;
  logic [7:0]      r_shift;
  logic [2:0]      r_bit;
  logic [c_cw-1:0] r_cnt;

  logic            w_cell_end;
  logic            w_stop_end;
  logic [c_cw-1:0] w_low_len;

  assign w_cell_end = (r_cnt == c_cell_end);
  assign w_stop_end = (r_cnt == c_stop_end);
  assign w_low_len  = r_shift[7] ? c_low1 : c_low0;

  // A non-last byte reports done in its final cycle so the next byte can be
  // loaded on the same edge without a gap cell.
  assign o_byte_done = r_active & (r_stop ? w_stop_end
                                          : (w_cell_end & (r_bit == 3'd7) & ~r_last));
  assign o_oe        = r_active & (r_stop | (r_cnt < w_low_len));
  assign o_stop      = r_active & r_stop;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_active <= 1'b0;
      r_stop   <= 1'b0;
      r_last   <= 1'b0;
      r_shift  <= 8'h00;
      r_bit    <= 3'd0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_stop   <= 1'b0;
      r_last   <= i_last;
      r_shift  <= i_byte;
      r_bit    <= 3'd0;
      r_cnt    <= '0;
    end else if (r_active) begin
      if (r_stop) begin
        if (w_stop_end) begin
          r_active <= 1'b0;
          r_stop   <= 1'b0;
        end else begin
          r_cnt <= r_cnt + c_cw'(1);
        end
      end else if (w_cell_end) begin
        r_cnt <= '0;
        if (r_bit == 3'd7) begin
          if (r_last) r_stop <= 1'b1;
          else        r_active <= 1'b0;
        end else begin
          r_shift <= {r_shift[6:0], 1'b0};
          r_bit   <= r_bit + 3'd1;
        end
      end else begin
        r_cnt <= r_cnt + c_cw'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/n64_joybus_device.sv
// ============================================================================
// Module      : n64_joybus_device
// Description : Joybus controller emulator: decodes host frames on the open-
//               drain line and answers info/reset and button-poll commands.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module n64_joybus_device
  import n64_joybus_pkg::*;
#(
  parameter int         CLK_PER_US  = 48,
  parameter logic [7:0] STATUS_BYTE = 8'h02,
  parameter int         IDLE_US     = 6,
  parameter int         TURN_US     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        joy_in,
  output logic        joy_oe,
  input  logic [15:0] buttons,
  input  logic [7:0]  stick_x,
  input  logic [7:0]  stick_y,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte,
  output logic        busy
);

  localparam int c_tmax_cyc = 16 * CLK_PER_US;
  localparam int c_tw       = $clog2(c_tmax_cyc + 1);
  localparam logic [c_tw-1:0] c_tmax     = c_tw'(c_tmax_cyc);
  localparam logic [c_tw-1:0] c_bit1_max = c_tw'(2 * CLK_PER_US - 1);
  localparam logic [c_tw-1:0] c_fault    = c_tw'(8 * CLK_PER_US);
  // The edge-detect cycle is itself the first cycle of the interval, hence -2.
  localparam logic [c_tw-1:0] c_idle_end = c_tw'(IDLE_US * CLK_PER_US - 2);
  localparam logic [c_tw-1:0] c_turn_end = c_tw'(TURN_US * CLK_PER_US - 2);

  jb_state_e       r_state, w_next;
  logic            r_sync1, r_sync2, r_prev;
  logic [c_tw-1:0] r_timer;
  logic [7:0]      r_rx_shift;
  logic [3:0]      r_rx_cnt;
  logic            r_cmd_valid;
  logic [7:0]      r_cmd_byte;
  logic [15:0]     r_snap_btn;
  logic [7:0]      r_snap_x, r_snap_y;
  logic [1:0]      r_byte_idx;

  logic            w_fall, w_rise, w_rx_bit, w_timer_clr;
  logic            w_shift_en, w_accept, w_start;
  logic [1:0]      w_tx_idx, w_last_idx;
  logic            w_tx_last, w_last_byte;
  logic [7:0]      w_tx_byte;
  logic            w_enc_oe, w_enc_stop, w_enc_done;

  assign w_fall      = r_prev & ~r_sync2;
  assign w_rise      = ~r_prev & r_sync2;
  assign w_rx_bit    = (r_timer < c_bit1_max);
  assign w_last_byte = (r_byte_idx == w_last_idx);

  always_comb begin
    w_last_idx = (r_cmd_byte == CMD_POLL) ? 2'd3 : 2'd2;
    w_tx_idx   = (r_state == S_TURNAROUND) ? 2'd0 : r_byte_idx + 2'd1;
    w_tx_last  = (w_tx_idx == w_last_idx);
    w_tx_byte  = 8'h00;
    if (r_cmd_byte == CMD_POLL) begin
      case (w_tx_idx)
        2'd0:    w_tx_byte = r_snap_btn[15:8];
        2'd1:    w_tx_byte = r_snap_btn[7:0];
        2'd2:    w_tx_byte = r_snap_x;
        default: w_tx_byte = r_snap_y;
      endcase
    end else begin
      case (w_tx_idx)
        2'd0:    w_tx_byte = INFO_HDR0;
        2'd1:    w_tx_byte = INFO_HDR1;
        2'd2:    w_tx_byte = STATUS_BYTE;
        default: w_tx_byte = 8'h00;
      endcase
    end
  end

  always_comb begin
    w_next     = r_state;
    w_shift_en = 1'b0;
    w_accept   = 1'b0;
    w_start    = 1'b0;
    case (r_state)
      S_IDLE: if (w_fall) w_next = S_RX_LOW;
      S_RX_LOW: begin
        if (w_rise) begin
          w_next     = S_RX_HIGH;
          w_shift_en = 1'b1;
        end else if (r_timer >= c_fault) begin
          w_next = S_WAIT_IDLE;
        end
      end
      S_RX_HIGH: begin
        if (w_fall)                       w_next = (r_rx_cnt == 4'd8) ? S_RX_STOP : S_RX_LOW;
        else if (r_timer >= c_idle_end)   w_next = S_IDLE;
      end
      S_RX_STOP: begin
        if (w_rise) begin
          if (is_supported(r_rx_shift)) begin
            w_next   = S_TURNAROUND;
            w_accept = 1'b1;
          end else begin
            w_next = S_WAIT_IDLE;
          end
        end else if (r_timer >= c_fault) begin
          w_next = S_WAIT_IDLE;
        end
      end
      S_TURNAROUND: begin
        if (w_fall) begin
          w_next = S_WAIT_IDLE;
        end else if (r_timer == c_turn_end) begin
          w_next  = S_TX_LOW;
          w_start = 1'b1;
        end
      end
      S_TX_LOW, S_TX_HIGH, S_TX_STOP: begin
        if (w_enc_done && w_last_byte) begin
          w_next = S_WAIT_IDLE;
        end else begin
          w_start = w_enc_done;
          if (w_enc_stop)    w_next = S_TX_STOP;
          else if (w_enc_oe) w_next = S_TX_LOW;
          else               w_next = S_TX_HIGH;
        end
      end
      S_WAIT_IDLE: if (r_sync2 && (r_timer == c_idle_end)) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_timer_clr = (w_next != r_state) | w_fall | w_rise |
                       ((r_state == S_WAIT_IDLE) & ~r_sync2);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_prev      <= 1'b1;
      r_timer     <= '0;
      r_rx_shift  <= 8'h00;
      r_rx_cnt    <= 4'd0;
      r_cmd_valid <= 1'b0;
      r_cmd_byte  <= 8'h00;
      r_snap_btn  <= 16'h0000;
      r_snap_x    <= 8'h00;
      r_snap_y    <= 8'h00;
      r_byte_idx  <= 2'd0;
    end else begin
      r_sync1     <= joy_in;
      r_sync2     <= r_sync1;
      r_prev      <= r_sync2;
      r_state     <= w_next;
      r_timer     <= w_timer_clr ? '0 : ((r_timer == c_tmax) ? r_timer : r_timer + c_tw'(1));
      r_cmd_valid <= w_accept;
      if ((r_state == S_IDLE) && w_fall) r_rx_cnt <= 4'd0;
      if (w_shift_en) begin
        r_rx_shift <= {r_rx_shift[6:0], w_rx_bit};
        r_rx_cnt   <= r_rx_cnt + 4'd1;
      end
      if (w_accept) begin
        r_cmd_byte <= r_rx_shift;
        r_snap_btn <= buttons;
        r_snap_x   <= stick_x;
        r_snap_y   <= stick_y;
      end
      if (w_start) r_byte_idx <= w_tx_idx;
    end
  end

  joybus_bit_encoder #(
    .CLK_PER_US (CLK_PER_US)
  ) u_enc (
    .clk         (clk),
    .reset       (reset),
    .i_start     (w_start),
    .i_byte      (w_tx_byte),
    .i_last      (w_tx_last),
    .o_oe        (w_enc_oe),
    .o_stop      (w_enc_stop),
    .o_byte_done (w_enc_done)
  );

  assign joy_oe    = w_enc_oe;
  assign cmd_valid = r_cmd_valid;
  assign cmd_byte  = r_cmd_byte;
  assign busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_n64_joybus_device.sv
// ============================================================================
// Module      : tb_n64_joybus_device
// Description : Scoreboard bench: host frames in, reply bytes decoded off
//               joy_oe and compared against queued hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_n64_joybus_device;

  localparam int C    = 4;
  localparam int IDLE = 6;
  localparam int TURN = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        host_pull;
  logic        joy_in;
  logic        joy_oe;
  logic [15:0] buttons;
  logic [7:0]  stick_x, stick_y;
  logic        cmd_valid;
  logic [7:0]  cmd_byte;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int rx_bytes = 0;
  int stops    = 0;
  int oe_rises = 0;
  logic [7:0] exp_bytes[$];
  logic [7:0] exp_cmds[$];

  always #5 clk = ~clk;
  assign joy_in = ~(host_pull | joy_oe);

  n64_joybus_device #(
    .CLK_PER_US (C),
    .STATUS_BYTE(8'h02),
    .IDLE_US    (IDLE),
    .TURN_US    (TURN)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .joy_in   (joy_in),
    .joy_oe   (joy_oe),
    .buttons  (buttons),
    .stick_x  (stick_x),
    .stick_y  (stick_y),
    .cmd_valid(cmd_valid),
    .cmd_byte (cmd_byte),
    .busy     (busy)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reply decoder: low length 1us -> 1, 3us -> 0, 2us -> stop.
  initial begin : mon_reply
    logic       prev;
    logic [7:0] cur;
    int         nb, start, cyc, len;
    bit         in_reply;
    prev = 1'b0; cur = 8'h00; nb = 0; start = 0; cyc = 0; in_reply = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        nb = 0;
        in_reply = 1'b0;
        prev = joy_oe;
      end else begin
        if (joy_oe && !prev) begin
          oe_rises++;
          if (in_reply) check("cell_period", cyc - start, 4 * C);
          in_reply = 1'b1;
          start = cyc;
        end else if (!joy_oe && prev) begin
          len = cyc - start;
          if (len == C || len == 3 * C) begin
            cur = {cur[6:0], (len == C)};
            nb++;
            if (nb == 8) begin
              nb = 0;
              rx_bytes++;
              if (exp_bytes.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_byte: got %02h expected none", cur);
              end else begin
                check("reply_byte", cur, exp_bytes.pop_front());
              end
            end
          end else if (len == 2 * C) begin
            check("stop_after_whole_bytes", nb, 0);
            in_reply = 1'b0;
            stops++;
          end else begin
            total++; bad++;
            $display("FAIL low_pulse_len: got %0d cycles expected %0d/%0d/%0d", len, C, 2 * C, 3 * C);
          end
        end
        prev = joy_oe;
      end
    end
  end

  initial begin : mon_cmd
    forever begin
      @(negedge clk);
      if (!reset && cmd_valid) begin
        if (exp_cmds.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_cmd: got %02h expected none", cmd_byte);
        end else begin
          check("cmd_byte", cmd_byte, exp_cmds.pop_front());
        end
      end
    end
  end

  task automatic host_bit(input logic b);
    host_pull = 1'b1;
    repeat (b ? C : 3 * C) @(negedge clk);
    host_pull = 1'b0;
    repeat (b ? 3 * C : C) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    logic [7:0] v;
    v = b;
    for (int i = 7; i >= 8 - nbits; i--) host_bit(v[i]);
  endtask

  // Stop bit; returns posedges from release until the reply's first low.
  task automatic send_stop_timed(output int n);
    host_pull = 1'b1;
    repeat (C) @(negedge clk);
    host_pull = 1'b0;
    n = 0;
    while (!joy_oe && n < 100) begin
      @(posedge clk); n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_busy_low(input string tag);
    int n;
    n = 0;
    while (busy && n < 500) begin @(negedge clk); n++; end
    check({tag, "_busy_low"}, busy, 0);
  endtask

  task automatic wait_bytes(input int target);
    int n;
    n = 0;
    while (rx_bytes < target && n < 2000) begin @(negedge clk); n++; end
    check("wait_bytes", rx_bytes, target);
  endtask

  task automatic expect_done(input string tag, input int st_target);
    int n;
    n = 0;
    while (stops < st_target && n < 3000) begin @(negedge clk); n++; end
    check({tag, "_stop_seen"}, stops, st_target);
    wait_busy_low(tag);
    check({tag, "_bytes_left"}, exp_bytes.size(), 0);
    check({tag, "_cmds_left"}, exp_cmds.size(), 0);
  endtask

  initial begin : main
    int n, r;
    reset = 1'b1; host_pull = 1'b0;
    buttons = 16'h0000; stick_x = 8'h00; stick_y = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_joy_oe", joy_oe, 0);
    check("reset_busy", busy, 0);
    check("reset_cmd_valid", cmd_valid, 0);
    check("reset_cmd_byte", cmd_byte, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Info: reply 05 00 02, first edge TURN us + 2 sync cycles after stop rise
    exp_cmds.push_back(8'h00);
    exp_bytes.push_back(8'h05); exp_bytes.push_back(8'h00); exp_bytes.push_back(8'h02);
    send_bits(8'h00, 8);
    send_stop_timed(n);
    check("turn_latency", n, TURN * C + 2);
    expect_done("info", 1);
    check("info_cmd_byte_held", cmd_byte, 8'h00);

    // Poll with inputs changed mid-reply
    buttons = 16'h9001; stick_x = 8'h7F; stick_y = 8'h80;
    exp_cmds.push_back(8'h01);
    exp_bytes.push_back(8'h90); exp_bytes.push_back(8'h01);
    exp_bytes.push_back(8'h7F); exp_bytes.push_back(8'h80);
    r = rx_bytes;
    send_bits(8'h01, 8);
    send_stop_timed(n);
    wait_bytes(r + 1);
    buttons = 16'hFFFF; stick_x = 8'h00; stick_y = 8'h00;
    expect_done("poll", 2);

    // Reset command answers like info
    exp_cmds.push_back(8'hFF);
    exp_bytes.push_back(8'h05); exp_bytes.push_back(8'h00); exp_bytes.push_back(8'h02);
    send_bits(8'hFF, 8);
    send_stop_timed(n);
    expect_done("rstcmd", 3);
    check("rstcmd_cmd_byte", cmd_byte, 8'hFF);

    // Unsupported 0x02 + 2 address bytes: silent, busy drops IDLE us after last edge
    r = oe_rises;
    send_bits(8'h02, 8); send_bits(8'h12, 8); send_bits(8'h34, 8);
    host_pull = 1'b1;
    repeat (C) @(negedge clk);
    host_pull = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk); n++;
      @(negedge clk);
    end
    check("unsup_busy_fall", n, IDLE * C + 2);
    check("unsup_no_reply", oe_rises, r);

    // Truncated frame: 5 bits then idle
    repeat (4) @(negedge clk);
    send_bits(8'hA8, 5);
    check("trunc_busy_mid", busy, 1);
    wait_busy_low("trunc");
    check("trunc_no_reply", oe_rises, r);

    // 10 us low fault
    repeat (4) @(negedge clk);
    host_pull = 1'b1;
    repeat (10 * C) @(negedge clk);
    check("fault_busy_mid", busy, 1);
    host_pull = 1'b0;
    wait_busy_low("fault");
    check("fault_no_reply", oe_rises, r);

    // Reset asserted during second byte of a poll reply
    repeat (4) @(negedge clk);
    buttons = 16'hA55A; stick_x = 8'h01; stick_y = 8'hFE;
    exp_cmds.push_back(8'h01);
    exp_bytes.push_back(8'hA5); exp_bytes.push_back(8'h5A);
    exp_bytes.push_back(8'h01); exp_bytes.push_back(8'hFE);
    r = rx_bytes;
    send_bits(8'h01, 8);
    send_stop_timed(n);
    wait_bytes(r + 1);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_joy_oe", joy_oe, 0);
    check("midreset_busy", busy, 0);
    exp_bytes.delete();
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Follow-up poll after the reset
    buttons = 16'h0F0F; stick_x = 8'hC3; stick_y = 8'h3C;
    exp_cmds.push_back(8'h01);
    exp_bytes.push_back(8'h0F); exp_bytes.push_back(8'h0F);
    exp_bytes.push_back(8'hC3); exp_bytes.push_back(8'h3C);
    r = stops;
    send_bits(8'h01, 8);
    send_stop_timed(n);
    check("post_reset_latency", n, TURN * C + 2);
    expect_done("post_reset", r + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
